// File: rtl/issue_queue_if.sv
// Insert, result-broadcast and dispatch signal bundle for the issue queue.
// master drives loads/broadcasts and accepts issues; slave is the queue itself.
interface issue_queue_if #(
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_CDB = 2
);
  logic                              load_valid;
  logic                              load_ready;
  logic [6:0]                        load_op;
  logic [TAG_W-1:0]                  load_tag;
  logic [DATA_W-1:0]                 load_pc;
  logic [DATA_W-1:0]                 load_v1;
  logic [DATA_W-1:0]                 load_v2;
  logic                              load_busy1;
  logic                              load_busy2;

  logic [NUM_CDB-1:0]                cdb_valid;
  logic [NUM_CDB-1:0][TAG_W-1:0]     cdb_tag;
  logic [NUM_CDB-1:0][DATA_W-1:0]    cdb_data;

  logic                              issue_valid;
  logic                              issue_ready;
  logic [6:0]                        issue_op;
  logic [TAG_W-1:0]                  issue_tag;
  logic [DATA_W-1:0]                 issue_v1;
  logic [DATA_W-1:0]                 issue_v2;
  logic [DATA_W-1:0]                 issue_pc;

  modport master (
    output load_valid, load_op, load_tag, load_pc, load_v1, load_v2,
           load_busy1, load_busy2, cdb_valid, cdb_tag, cdb_data, issue_ready,
    input  load_ready, issue_valid, issue_op, issue_tag, issue_v1, issue_v2,
           issue_pc
  );

  modport slave (
    input  load_valid, load_op, load_tag, load_pc, load_v1, load_v2,
           load_busy1, load_busy2, cdb_valid, cdb_tag, cdb_data, issue_ready,
    output load_ready, issue_valid, issue_op, issue_tag, issue_v1, issue_v2,
           issue_pc
  );
endinterface

// File: rtl/issue_queue.sv
// Reservation-station issue queue: operand wakeup from result broadcasts,
// oldest-ready-first dispatch, lowest-free-slot insertion.
module issue_queue #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_CDB = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  issue_queue_if.slave               bus,
  output logic [$clog2(DEPTH+1)-1:0] num_free,
  output logic                       full,
  output logic                       empty
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(DEPTH);

  typedef logic [NUM_CDB-1:0][TAG_W-1:0]  cdb_tag_t;
  typedef logic [NUM_CDB-1:0][DATA_W-1:0] cdb_data_t;

  // Returns {hit, data}; the lowest-numbered matching bus wins.
  function automatic logic [DATA_W:0] cdb_match(
    input logic [TAG_W-1:0]   tag,
    input logic [NUM_CDB-1:0] vld,
    input cdb_tag_t           tags,
    input cdb_data_t          data
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int unsigned k = 0; k < NUM_CDB; k++) begin
      if (!r[DATA_W] && vld[k] && (tags[k] == tag)) begin
        r = {1'b1, data[k]};
      end
    end
    return r;
  endfunction

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  busy1_q;
  logic [DEPTH-1:0]  busy2_q;
  logic [6:0]        op_q  [DEPTH];
  logic [TAG_W-1:0]  tag_q [DEPTH];
  logic [DATA_W-1:0] pc_q  [DEPTH];
  logic [DATA_W-1:0] v1_q  [DEPTH];
  logic [DATA_W-1:0] v2_q  [DEPTH];
  // Age matrix instead of a sequence counter, so ordering never wraps:
  // older_q[i][j] set means entry i was accepted before entry j.
  logic [DEPTH-1:0]  older_q [DEPTH];

  logic [DEPTH-1:0]  ready;
  logic [DEPTH-1:0]  sel;
  logic [IW-1:0]     sel_idx;
  logic [IW-1:0]     free_idx;
  logic              any_ready;
  logic              load_fire;
  logic              issue_fire;
  logic [DATA_W:0]   wake1 [DEPTH];
  logic [DATA_W:0]   wake2 [DEPTH];
  logic [DATA_W:0]   byp1;
  logic [DATA_W:0]   byp2;

  assign ready     = valid_q & ~busy1_q & ~busy2_q;
  assign any_ready = |ready;

  always_comb begin
    logic blocked;
    sel     = '0;
    sel_idx = '0;
    blocked = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      blocked = 1'b0;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (ready[j] && older_q[j][i]) blocked = 1'b1;
      end
      sel[i] = ready[i] && !blocked;
      if (sel[i]) sel_idx = IW'(i);
    end
  end

  always_comb begin
    logic found;
    free_idx = '0;
    found    = 1'b0;
    num_free = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      num_free = num_free + CW'(!valid_q[i]);
      if (!found && !valid_q[i]) begin
        free_idx = IW'(i);
        found    = 1'b1;
      end
    end
  end

  assign full           = (num_free == '0);
  assign empty          = (num_free == CW'(DEPTH));
  assign bus.load_ready = (num_free != '0) && !flush;
  assign bus.issue_valid = any_ready && !flush;
  assign load_fire      = bus.load_valid && bus.load_ready;
  assign issue_fire     = bus.issue_valid && bus.issue_ready;

  // One-hot select OR-mux: all fields read zero when nothing is ready.
  always_comb begin
    bus.issue_op  = '0;
    bus.issue_tag = '0;
    bus.issue_pc  = '0;
    bus.issue_v1  = '0;
    bus.issue_v2  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        bus.issue_op  = bus.issue_op  | op_q[i];
        bus.issue_tag = bus.issue_tag | tag_q[i];
        bus.issue_pc  = bus.issue_pc  | pc_q[i];
        bus.issue_v1  = bus.issue_v1  | v1_q[i];
        bus.issue_v2  = bus.issue_v2  | v2_q[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wake1[i] = cdb_match(v1_q[i][TAG_W-1:0], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      wake2[i] = cdb_match(v2_q[i][TAG_W-1:0], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end
    byp1 = cdb_match(bus.load_v1[TAG_W-1:0], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    byp2 = cdb_match(bus.load_v2[TAG_W-1:0], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && busy1_q[i] && wake1[i][DATA_W]) begin
          v1_q[i]    <= wake1[i][DATA_W-1:0];
          busy1_q[i] <= 1'b0;
        end
        if (valid_q[i] && busy2_q[i] && wake2[i][DATA_W]) begin
          v2_q[i]    <= wake2[i][DATA_W-1:0];
          busy2_q[i] <= 1'b0;
        end
      end

      if (issue_fire) valid_q[sel_idx] <= 1'b0;

      // The load slot is currently invalid, so it never collides with the
      // wakeup or issue updates above.
      if (load_fire) begin
        valid_q[free_idx]  <= 1'b1;
        op_q[free_idx]     <= bus.load_op;
        tag_q[free_idx]    <= bus.load_tag;
        pc_q[free_idx]     <= bus.load_pc;
        v1_q[free_idx]     <= (bus.load_busy1 && byp1[DATA_W]) ? byp1[DATA_W-1:0] : bus.load_v1;
        v2_q[free_idx]     <= (bus.load_busy2 && byp2[DATA_W]) ? byp2[DATA_W-1:0] : bus.load_v2;
        busy1_q[free_idx]  <= bus.load_busy1 && !byp1[DATA_W];
        busy2_q[free_idx]  <= bus.load_busy2 && !byp2[DATA_W];
        older_q[free_idx]  <= '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
          if (IW'(j) != free_idx) older_q[j][free_idx] <= 1'b1;
        end
      end
    end
  end
endmodule
